fe_redirect_ctrl: RTL and testbench
===================================

Name: fe_redirect_ctrl

Overview:
- Front-end PC redirect and flush sequencer for the 16-bit Purple_Jade fetch/decode/branch pipe.
- Arbitrates four PC-change sources: reset boot, backend mispredict, interrupt entry and static branch-stage take.
- Drives the single redirect PC into pc_next, issues per-stage flushes, and masks front-end valid while the pipe refills.
- Replaces the ad-hoc take_branch/flush wiring in the front-end top level.

Parameters:
- WORD_SIZE_P, 16, PC/target width.
- RESET_VECTOR_P, 16'h0000, first fetch PC after reset.
- IRQ_VECTOR_P, 16'h0004, interrupt handler entry PC.
- REFILL_CYCLES_P, 2, cycles the valid mask stays low after any redirect; legal range 1..15.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- ready_i  in  1  backend ready; low = front-end stall.
- mis_predict_i  in  1  backend mispredict, single-cycle pulse.
- mis_target_i  in  WORD_SIZE_P  corrected PC.
- br_take_i  in  1  branch stage predicts taken.
- br_target_i  in  WORD_SIZE_P  branch stage target.
- irq_i  in  1  level interrupt request.
- irq_ret_pc_i  in  WORD_SIZE_P  PC of the oldest valid front-end instruction.
- redirect_v_o  out  1  load redirect_pc_o into the PC.
- redirect_pc_o  out  WORD_SIZE_P  redirect PC.
- flush_f_d_o  out  1  flush fetch/decode pipe.
- flush_d_b_o  out  1  flush decode/branch pipe.
- valid_mask_o  out  1  ANDed with front-end valid_o.
- irq_ack_o  out  1  interrupt taken, single-cycle pulse.
- epc_o  out  WORD_SIZE_P  saved return PC.
- perf_redirects_o  out  16  redirect count (see Optional Feature).
- perf_mispredicts_o  out  16  mispredict count (see Optional Feature).

Interface rules:
- Single clock clk_i.
- reset_i is synchronous, active-high.

Behaviour:
- Reset (reset_i high at a rising edge):
  - State BOOT; refill counter 0; irq pending 0; epc_o 0; perf counters 0.
  - All outputs 0, except valid_mask_o 0 and redirect_pc_o = RESET_VECTOR_P.
- States: BOOT, RUN, REFILL.
- BOOT: lasts one cycle after reset deasserts.
  - Drive redirect_v_o=1, redirect_pc_o=RESET_VECTOR_P, both flushes 1.
  - Next state REFILL, counter = REFILL_CYCLES_P.
- Redirect priority, evaluated combinationally each cycle in RUN and REFILL: mis_predict_i > irq take > br_take_i.
- Mispredict: accepted in any state except BOOT, regardless of ready_i.
  - redirect_v_o=1, redirect_pc_o=mis_target_i, both flushes 1, same cycle (zero latency).
  - Next state REFILL, counter reloads to REFILL_CYCLES_P, also when already in REFILL.
- Irq take: requires RUN, ready_i=1, mis_predict_i=0 and irq pending.
  - irq pending is set by irq_i, sticky until taken or reset.
  - redirect_pc_o=IRQ_VECTOR_P, flushes 1, irq_ack_o=1.
  - epc_o <= irq_ret_pc_i at the edge.
  - Next state REFILL. Pending clears.
  - No irq is taken in BOOT or REFILL; it waits.
- Branch take: honoured only in RUN.
  - redirect_pc_o=br_target_i, flushes 1, next state REFILL.
  - Honoured even when ready_i=0, because a flush overrides a stall.
  - br_take_i is ignored in REFILL (those stages hold flushed bubbles).
- REFILL:
  - valid_mask_o=0.
  - Counter decrements only on cycles with ready_i=1 and no new redirect.
  - When the counter reaches 1 and decrements: next state RUN, valid_mask_o=1 from the following cycle.
- RUN: valid_mask_o=1 unless a redirect fires this cycle, in which case valid_mask_o=0 that cycle.
- When no redirect fires: redirect_v_o=0, flushes 0, redirect_pc_o = last driven value (registered copy).
- Reset mid-REFILL or while irq is pending: everything is discarded and the block returns to BOOT.
- Simultaneous mispredict and irq: mispredict wins; irq stays pending and is taken after the refill.
- epc_o is held until the next irq take.

Optional Feature:
- Macro: FE_REDIRECT_PERF_EN.
- Defined:
  - perf_redirects_o counts every cycle with redirect_v_o=1, excluding BOOT.
  - perf_mispredicts_o counts accepted mispredicts.
  - Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- Undefined: both outputs tie to 0 and no counter flops are instantiated.

Test Plan:
- Boot: release reset at cycle 0.
  - Cycle 1: redirect_v_o=1, pc=0x0000, flushes=1.
  - valid_mask_o=0 for 2 ready cycles, then 1.
- Branch in RUN with ready_i=1: br_take_i=1, br_target_i=0x0120.
  - Same-cycle redirect to 0x0120, flushes=1, mask low 2 cycles.
  - br_take_i held high during REFILL produces no redirect.
- Mispredict during REFILL: mis_predict_i=1, mis_target_i=0x0040 one cycle after a branch redirect.
  - Redirect to 0x0040; counter restarts; mask low 2 further ready cycles.
- Irq vs. mispredict: irq_i=1 with mis_predict_i=1 in the same RUN cycle.
  - Redirect to the mispredict target.
  - After the refill: irq_ack_o=1, pc=0x0004, epc_o=irq_ret_pc_i (e.g. 0x0033).
- Stall hold: ready_i=0 for 5 cycles in REFILL.
  - Counter frozen and mask stays 0.
  - A branch take with ready_i=0 in RUN still redirects.
- Perf (macro defined): 3 mispredicts and 2 branch takes.
  - perf_mispredicts_o=3, perf_redirects_o=5.
  - Macro undefined: both read 0.

Source files
------------

// File: rtl/fe_redirect_ctrl_if.sv
// Redirect-controller bus: backend/branch/irq requests in, PC redirect, flushes and status out.
// The master side drives requests; the slave side is the redirect controller.
interface fe_redirect_ctrl_if #(
    parameter int WORD_SIZE_P = 16
);
    logic                   ready_i;
    logic                   mis_predict_i;
    logic [WORD_SIZE_P-1:0] mis_target_i;
    logic                   br_take_i;
    logic [WORD_SIZE_P-1:0] br_target_i;
    logic                   irq_i;
    logic [WORD_SIZE_P-1:0] irq_ret_pc_i;
    logic                   redirect_v_o;
    logic [WORD_SIZE_P-1:0] redirect_pc_o;
    logic                   flush_f_d_o;
    logic                   flush_d_b_o;
    logic                   valid_mask_o;
    logic                   irq_ack_o;
    logic [WORD_SIZE_P-1:0] epc_o;
    logic [15:0]            perf_redirects_o;
    logic [15:0]            perf_mispredicts_o;

    modport master (
        output ready_i, mis_predict_i, mis_target_i, br_take_i, br_target_i,
               irq_i, irq_ret_pc_i,
        input  redirect_v_o, redirect_pc_o, flush_f_d_o, flush_d_b_o,
               valid_mask_o, irq_ack_o, epc_o, perf_redirects_o, perf_mispredicts_o
    );

    modport slave (
        input  ready_i, mis_predict_i, mis_target_i, br_take_i, br_target_i,
               irq_i, irq_ret_pc_i,
        output redirect_v_o, redirect_pc_o, flush_f_d_o, flush_d_b_o,
               valid_mask_o, irq_ack_o, epc_o, perf_redirects_o, perf_mispredicts_o
    );
endinterface

// File: rtl/fe_redirect_ctrl.sv
// Front-end PC redirect / flush sequencer.
// Arbitrates mispredict > irq take > branch take, drives the redirect PC and
// flushes, and masks front-end valid while the pipe refills.
// Optional perf counters are built when FE_REDIRECT_PERF_EN is defined.
module fe_redirect_ctrl #(
    parameter int                   WORD_SIZE_P     = 16,
    parameter logic [WORD_SIZE_P-1:0] RESET_VECTOR_P = 16'h0000,
    parameter logic [WORD_SIZE_P-1:0] IRQ_VECTOR_P   = 16'h0004,
    parameter int                   REFILL_CYCLES_P = 2
) (
    input logic               clk_i,
    input logic               reset_i,
    fe_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_REFILL} state_t;

    localparam logic [3:0] REFILL_INIT = 4'(REFILL_CYCLES_P);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   irq_pend_q;
    logic [WORD_SIZE_P-1:0] epc_q;
    logic [WORD_SIZE_P-1:0] last_pc_q;

    logic                   irq_seen;
    logic                   irq_take;
    logic                   br_hit;
    logic                   redirect_v;
    logic [WORD_SIZE_P-1:0] redirect_pc;
    logic                   mask;
    logic                   mis_acc;

    // A level irq counts as pending in the same cycle it is first seen.
    assign irq_seen = irq_pend_q | bus.irq_i;

    // Next-state, redirect arbitration and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        irq_take    = 1'b0;
        br_hit      = 1'b0;
        redirect_v  = 1'b0;
        redirect_pc = last_pc_q;
        mask        = 1'b0;
        mis_acc     = 1'b0;
        if (reset_i) begin
            redirect_pc = RESET_VECTOR_P;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    redirect_v  = 1'b1;
                    redirect_pc = RESET_VECTOR_P;
                    state_d     = ST_REFILL;
                    cnt_d       = REFILL_INIT;
                end
                ST_RUN, ST_REFILL: begin
                    irq_take = (state_q == ST_RUN) && bus.ready_i && !bus.mis_predict_i && irq_seen;
                    br_hit   = (state_q == ST_RUN) && !bus.mis_predict_i && !irq_take && bus.br_take_i;
                    if (bus.mis_predict_i) begin
                        mis_acc     = 1'b1;
                        redirect_v  = 1'b1;
                        redirect_pc = bus.mis_target_i;
                    end else if (irq_take) begin
                        redirect_v  = 1'b1;
                        redirect_pc = IRQ_VECTOR_P;
                    end else if (br_hit) begin
                        redirect_v  = 1'b1;
                        redirect_pc = bus.br_target_i;
                    end
                    if (redirect_v) begin
                        state_d = ST_REFILL;
                        cnt_d   = REFILL_INIT;
                    end else if (state_q == ST_REFILL && bus.ready_i) begin
                        if (cnt_q == 4'd1) begin
                            state_d = ST_RUN;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    mask = (state_q == ST_RUN) && !redirect_v;
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // State, refill counter, irq pending, saved return PC and last driven PC.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_BOOT;
            cnt_q      <= 4'd0;
            irq_pend_q <= 1'b0;
            epc_q      <= '0;
            last_pc_q  <= RESET_VECTOR_P;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_pend_q <= irq_seen & ~irq_take;
            if (irq_take)   epc_q     <= bus.irq_ret_pc_i;
            if (redirect_v) last_pc_q <= redirect_pc;
        end
    end

    assign bus.redirect_v_o  = redirect_v;
    assign bus.redirect_pc_o = redirect_pc;
    assign bus.flush_f_d_o   = redirect_v;
    assign bus.flush_d_b_o   = redirect_v;
    assign bus.valid_mask_o  = mask;
    assign bus.irq_ack_o     = irq_take;
    assign bus.epc_o         = epc_q;

`ifdef FE_REDIRECT_PERF_EN
    logic [15:0] perf_red_q;
    logic [15:0] perf_mis_q;

    // Saturating redirect (boot excluded) and accepted-mispredict counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_red_q <= '0;
            perf_mis_q <= '0;
        end else begin
            if (redirect_v && state_q != ST_BOOT && perf_red_q != 16'hFFFF)
                perf_red_q <= perf_red_q + 16'd1;
            if (mis_acc && perf_mis_q != 16'hFFFF)
                perf_mis_q <= perf_mis_q + 16'd1;
        end
    end

    assign bus.perf_redirects_o   = perf_red_q;
    assign bus.perf_mispredicts_o = perf_mis_q;
`else
    assign bus.perf_redirects_o   = 16'd0;
    assign bus.perf_mispredicts_o = 16'd0;
`endif
endmodule

// File: tb/tb_fe_redirect_ctrl.sv
// Bench for fe_redirect_ctrl: directed test-plan scenarios then random traffic,
// checked every cycle against a cycle-level reference model.
module tb_fe_redirect_ctrl;
    localparam logic [15:0] RV     = 16'h0000;
    localparam logic [15:0] IV     = 16'h0004;
    localparam int          REFILL = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    fe_redirect_ctrl_if #(.WORD_SIZE_P(16)) bus ();

    fe_redirect_ctrl #(
        .WORD_SIZE_P(16), .RESET_VECTOR_P(RV), .IRQ_VECTOR_P(IV), .REFILL_CYCLES_P(REFILL)
    ) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: booting flag, cycles of refill left (0 = running normally).
    bit          m_boot = 1'b1;
    int          m_left = 0;
    bit          m_pend = 1'b0;
    logic [15:0] m_epc  = '0;
    logic [15:0] m_last = RV;
    int          m_nred = 0;
    int          m_nmis = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit mp, input logic [15:0] mt,
                        input bit br, input logic [15:0] bt, input bit irq,
                        input logic [15:0] ret);
        bit          e_v, e_mask, e_ack, take, run, brh;
        logic [15:0] e_pc;
        int          e_pr, e_pm;
        @(negedge clk);
        reset = r;
        bus.ready_i = rdy; bus.mis_predict_i = mp; bus.mis_target_i = mt;
        bus.br_take_i = br; bus.br_target_i = bt; bus.irq_i = irq; bus.irq_ret_pc_i = ret;
        #1;
        e_v = 0; e_mask = 0; e_ack = 0; take = 0; e_pc = m_last;
        run = 0;
        if (r) begin
            e_pc = RV;
        end else if (m_boot) begin
            e_v = 1; e_pc = RV;
        end else begin
            run  = (m_left == 0);
            take = run && rdy && !mp && (m_pend || irq);
            brh  = run && !mp && !take && br;
            e_v  = mp || take || brh;
            e_pc = mp ? mt : take ? IV : brh ? bt : m_last;
            e_ack  = take;
            e_mask = run && !e_v;
        end
`ifdef FE_REDIRECT_PERF_EN
        e_pr = m_nred; e_pm = m_nmis;
`else
        e_pr = 0; e_pm = 0;
`endif
        check_val("redirect_v", 32'(bus.redirect_v_o), 32'(e_v));
        check_val("redirect_pc", 32'(bus.redirect_pc_o), 32'(e_pc));
        check_val("flush_f_d", 32'(bus.flush_f_d_o), 32'(e_v));
        check_val("flush_d_b", 32'(bus.flush_d_b_o), 32'(e_v));
        check_val("valid_mask", 32'(bus.valid_mask_o), 32'(e_mask));
        check_val("irq_ack", 32'(bus.irq_ack_o), 32'(e_ack));
        check_val("epc", 32'(bus.epc_o), 32'(m_epc));
        check_val("perf_redirects", 32'(bus.perf_redirects_o), 32'(e_pr));
        check_val("perf_mispredicts", 32'(bus.perf_mispredicts_o), 32'(e_pm));
        @(posedge clk);
        if (r) begin
            m_boot = 1; m_left = 0; m_pend = 0; m_epc = '0; m_last = RV; m_nred = 0; m_nmis = 0;
        end else if (m_boot) begin
            m_boot = 0; m_left = REFILL; m_pend = m_pend || irq;
        end else begin
            if (e_v) begin
                m_left = REFILL;
                m_last = e_pc;
                if (m_nred < 16'hFFFF) m_nred++;
                if (mp && m_nmis < 16'hFFFF) m_nmis++;
            end else if (!run && rdy) begin
                m_left = m_left - 1;
            end
            m_pend = (m_pend || irq) && !take;
            if (take) m_epc = ret;
        end
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(0, rdy, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.ready_i = 1; bus.mis_predict_i = 0; bus.mis_target_i = '0;
        bus.br_take_i = 0; bus.br_target_i = '0; bus.irq_i = 0; bus.irq_ret_pc_i = '0;
        // Reset then boot redirect and refill.
        step(1, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        step(1, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        idle(1, 4);
        // Branch in RUN, mispredict one cycle later, branch held during refill ignored.
        step(0, 1, 0, 16'h0, 1, 16'h0120, 0, 16'h0);
        step(0, 1, 1, 16'h0040, 0, 16'h0, 0, 16'h0);
        step(0, 1, 0, 16'h0, 1, 16'h0999, 0, 16'h0);
        step(0, 1, 0, 16'h0, 1, 16'h0999, 0, 16'h0);
        idle(1, 1);
        // Irq and mispredict together: mispredict wins, irq taken after refill.
        step(0, 1, 1, 16'h0050, 0, 16'h0, 1, 16'h0011);
        idle(1, 2);
        step(0, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0033);
        idle(1, 3);
        // Stall in refill, then a branch with ready low in RUN.
        step(0, 1, 1, 16'h0060, 0, 16'h0, 0, 16'h0);
        idle(0, 5);
        idle(1, 2);
        step(0, 0, 0, 16'h0, 1, 16'h0200, 0, 16'h0);
        idle(1, 3);
        // Reset while irq pending in refill discards it.
        step(0, 1, 1, 16'h0070, 0, 16'h0, 1, 16'h0044);
        step(1, 1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        idle(1, 5);
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), 16'($urandom),
                 ($urandom_range(0, 3) == 0), 16'($urandom),
                 ($urandom_range(0, 11) == 0), 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
